// File: rtl/nios_platform_pio_pkg.sv
// Shared constants for the pulse-capable output PIO: register word addresses
// and the pulse-timer state encoding.
package nios_platform_pio_pkg;

    localparam logic [1:0] ADDR_DATA      = 2'd0;
    localparam logic [1:0] ADDR_PULSE_LEN = 2'd1;
    localparam logic [1:0] ADDR_PULSE     = 2'd2;
    localparam logic [1:0] ADDR_OUTSET    = 2'd3;

    localparam int PULSE_LEN_W = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_PULSE = 1'b1
    } pulse_state_e;

endpackage

// File: rtl/pio_pulse_timer.sv
// Pulse-length down-counter and IDLE/PULSE state machine; busy is high exactly
// while a pulse is being driven.
module pio_pulse_timer
    import nios_platform_pio_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [PULSE_LEN_W-1:0] len,
    output logic                   busy
);

    pulse_state_e           state_q, state_d;
    logic [PULSE_LEN_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (abort) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (start) begin
            // A start while already pulsing simply reloads the count.
            state_d = ST_PULSE;
            cnt_d   = len;
        end else if (state_q == ST_PULSE) begin
            if (cnt_q == PULSE_LEN_W'(1)) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - PULSE_LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == ST_PULSE);

endmodule

// File: rtl/nios_platform_pio_out_pulse.sv
// Avalon-MM output PIO with a level DATA register plus a timed pulse mask
// OR-ed onto the outputs while the pulse timer is busy.
module nios_platform_pio_out_pulse
    import nios_platform_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic [WIDTH-1:0]       data_q, data_d;
    logic [PULSE_LEN_W-1:0] len_q, len_d;
    logic [WIDTH-1:0]       mask_q, mask_d;
    logic [31:0]            readdata_q, readdata_d;

    logic                   wr_en;
    logic                   pulse_wr;
    logic                   start;
    logic                   abort;
    logic                   busy;
    logic [WIDTH-1:0]       wr_mask;
    logic [WIDTH-1:0]       active_mask;
    logic                   unused_wdata;

    assign wr_en    = chipselect && !write_n;
    assign wr_mask  = writedata[WIDTH-1:0];
    assign pulse_wr = wr_en && (address == ADDR_PULSE);
    assign start    = pulse_wr && (wr_mask != '0) && (len_q != '0);
    assign abort    = pulse_wr && !start;

    assign unused_wdata = ^writedata[31:PULSE_LEN_W];

    pio_pulse_timer u_timer (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .abort (abort),
        .len   (len_q),
        .busy  (busy)
    );

    // Mask is only meaningful while busy; gating here hides the one-cycle
    // lag before the stale mask is cleared after a natural pulse end.
    assign active_mask = mask_q & {WIDTH{busy}};

    always_comb begin
        data_d = data_q;
        len_d  = len_q;
        mask_d = busy ? mask_q : '0;
        if (start) begin
            mask_d = wr_mask;
        end else if (abort) begin
            mask_d = '0;
        end
        if (wr_en && address == ADDR_DATA) begin
            data_d = wr_mask;
        end
        if (wr_en && address == ADDR_OUTSET) begin
            data_d = data_q | wr_mask;
        end
        if (wr_en && address == ADDR_PULSE_LEN) begin
            len_d = writedata[PULSE_LEN_W-1:0];
        end
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA:      readdata_d = 32'(data_q);
            ADDR_PULSE_LEN: readdata_d = 32'(len_q);
            ADDR_PULSE:     readdata_d = 32'(busy) | (32'(active_mask) << 8);
            default:        readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q     <= WIDTH'(RESET_VALUE);
            len_q      <= '0;
            mask_q     <= '0;
            readdata_q <= '0;
        end else begin
            data_q     <= data_d;
            len_q      <= len_d;
            mask_q     <= mask_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign out_port = data_q | active_mask;

endmodule

// File: tb/tb_nios_platform_pio_out_pulse.sv
// Directed bench for the pulse output PIO: register access, pulse timing,
// restart, abort, masked writes and reset during a pulse.
module tb_nios_platform_pio_out_pulse;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    int errors = 0;
    int checks = 0;

    nios_platform_pio_out_pulse #(.WIDTH(8), .RESET_VALUE(0)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
        $display("check %-14s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        tick();
        check(tag, readdata, exp);
    endtask

    initial begin
        int bad;
        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        tick();
        tick();
        check("rst_out", 32'(out_port), 32'h0);
        check("rst_rdata", readdata, 32'h0);
        reset = 1'b0;

        // DATA write visible on the write edge, readable one cycle later
        wr(2'd0, 32'h0000_00A5);
        check("data_out", 32'(out_port), 32'hA5);
        rd("data_rd", 2'd0, 32'h0000_00A5);
        rd("len_rst_rd", 2'd1, 32'h0);

        // 3-cycle pulse on bit 7
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h0);
        wr(2'd2, 32'h80);
        check("p3_c1", 32'(out_port), 32'h80);
        rd("p3_rd", 2'd2, 32'h0000_8001);
        check("p3_c2", 32'(out_port), 32'h80);
        tick();
        check("p3_c3", 32'(out_port), 32'h80);
        tick();
        check("p3_end", 32'(out_port), 32'h00);
        tick();
        check("p3_idle_rd", readdata, 32'h0);

        // Restart with a new mask at cycle 4 of a 10-cycle pulse
        wr(2'd1, 32'd10);
        wr(2'd2, 32'h01);
        check("rs_c1", 32'(out_port), 32'h01);
        tick();
        tick();
        check("rs_c3", 32'(out_port), 32'h01);
        wr(2'd2, 32'h02);
        check("rs_swap", 32'(out_port), 32'h02);
        for (int i = 0; i < 9; i++) begin
            tick();
            check("rs_hold", 32'(out_port), 32'h02);
        end
        tick();
        check("rs_end", 32'(out_port), 32'h00);

        // Zero length: no pulse
        wr(2'd1, 32'd0);
        wr(2'd2, 32'hFF);
        check("len0_out", 32'(out_port), 32'h00);
        rd("len0_busy", 2'd2, 32'h0);

        // OUTSET during a pulse, then abort with a zero mask
        wr(2'd1, 32'd5);
        wr(2'd2, 32'h0F);
        check("ab_start", 32'(out_port), 32'h0F);
        wr(2'd3, 32'h40);
        check("ab_outset", 32'(out_port), 32'h4F);
        wr(2'd2, 32'h00);
        check("ab_abort", 32'(out_port), 32'h40);
        rd("ab_busy", 2'd2, 32'h0);

        // OUTSET merge, OUTSET reads zero, unselected write ignored
        wr(2'd0, 32'h01);
        wr(2'd3, 32'h10);
        check("os_out", 32'(out_port), 32'h11);
        rd("os_data_rd", 2'd0, 32'h11);
        rd("os_rd0", 2'd3, 32'h0);
        address    = 2'd0;
        writedata  = 32'hFF;
        chipselect = 1'b0;
        write_n    = 1'b0;
        tick();
        write_n = 1'b1;
        check("nocs_out", 32'(out_port), 32'h11);
        rd("nocs_rd", 2'd0, 32'h11);

        // Reset at cycle 2 of a 5-cycle pulse, with a simultaneous DATA write
        wr(2'd0, 32'h00);
        wr(2'd1, 32'd5);
        wr(2'd2, 32'h04);
        check("rp_c1", 32'(out_port), 32'h04);
        tick();
        reset      = 1'b1;
        address    = 2'd0;
        writedata  = 32'hFF;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        check("rp_out", 32'(out_port), 32'h00);
        check("rp_rdata", readdata, 32'h0);
        reset = 1'b0;
        rd("rp_busy", 2'd2, 32'h0);
        rd("rp_len", 2'd1, 32'h0);

        // Maximum length counts the full 65535 cycles
        wr(2'd1, 32'h0000_FFFF);
        rd("max_len_rd", 2'd1, 32'h0000_FFFF);
        wr(2'd2, 32'h01);
        bad = 0;
        for (int i = 1; i < 65535; i++) begin
            if (out_port !== 8'h01) bad++;
            tick();
        end
        check("max_hold_bad", 32'(bad), 32'h0);
        check("max_last", 32'(out_port), 32'h01);
        tick();
        check("max_end", 32'(out_port), 32'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
